// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: counter update, reset value
// and PHT index hash.
package bp_pkg;

  localparam int CNT_W_MAX = 8;
  localparam int IDX_W_MAX = 16;

  typedef enum logic {
    REDIRECT_TARGET = 1'b0,
    REDIRECT_SEQ    = 1'b1
  } redirect_e;

  function automatic logic [CNT_W_MAX-1:0] cnt_update(input logic [CNT_W_MAX-1:0] cnt,
                                                      input logic taken,
                                                      input int cnt_bits);
    logic [CNT_W_MAX-1:0] top;
    top = (CNT_W_MAX'(1) << cnt_bits) - CNT_W_MAX'(1);
    if (taken) begin
      cnt_update = (cnt == top) ? cnt : cnt + CNT_W_MAX'(1);
    end else begin
      cnt_update = (cnt == {CNT_W_MAX{1'b0}}) ? cnt : cnt - CNT_W_MAX'(1);
    end
  endfunction

  // Weakly not-taken: just below the taken threshold, 0 for a 1-bit counter.
  function automatic logic [CNT_W_MAX-1:0] weak_not_taken(input int cnt_bits);
    return (CNT_W_MAX'(1) << (cnt_bits - 1)) - CNT_W_MAX'(1);
  endfunction

  function automatic logic [IDX_W_MAX-1:0] idx_hash(input logic [IDX_W_MAX-1:0] pc_bits,
                                                    input logic [IDX_W_MAX-1:0] ghr,
                                                    input logic gshare);
    return gshare ? (pc_bits ^ ghr) : pc_bits;
  endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter_table.sv
// Pattern history table of saturating counters: synchronous reset to weakly
// not-taken, one asynchronous read port, one read-modify-write training port.
module sat_counter_table
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int CNT_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [CNT_BITS-1:0] rd_cnt,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CNT_W_MAX-1:0] RST_FULL = weak_not_taken(CNT_BITS);
  localparam logic [CNT_BITS-1:0]  RST_VAL  = RST_FULL[CNT_BITS-1:0];

  logic [CNT_BITS-1:0]  pht_r [ENTRIES];
  logic [CNT_W_MAX-1:0] upd_s;

  // Next value of the entry being trained.
  always_comb begin
    upd_s = cnt_update(CNT_W_MAX'(pht_r[wr_idx]), wr_taken, CNT_BITS);
  end

  // Table storage; the read port sees the pre-update value in a training cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_r[i] <= RST_VAL;
      end
    end else if (wr_en) begin
      pht_r[wr_idx] <= upd_s[CNT_BITS-1:0];
    end else begin
      pht_r[wr_idx] <= pht_r[wr_idx];
    end
  end

  assign rd_cnt = pht_r[rd_idx];

endmodule

// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor: PHT lookup at fetch, misprediction resolution and
// training at execute, optional gshare history and saturating statistics.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int CNT_BITS = 2,
  parameter int GSHARE   = 0,
  parameter int STAT_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [XLEN-1:0]     f_pc,
  output logic                f_pred_taken,
  output logic [IDX_BITS-1:0] f_idx,
  input  logic                e_valid,
  input  logic                e_branch,
  input  logic                e_jump,
  input  logic [IDX_BITS-1:0] e_idx,
  input  logic                e_pred_taken,
  input  logic                e_actual_taken,
  output logic                e_flush,
  output logic                e_target_sel,
  output logic                e_pred_correct,
  output logic [STAT_W-1:0]   stat_branches,
  output logic [STAT_W-1:0]   stat_mispredicts
);

  logic [IDX_BITS-1:0]  ghr_r;
  logic [IDX_W_MAX-1:0] hash_s;
  logic [CNT_BITS-1:0]  rd_cnt_s;
  logic                 cf_s;
  logic                 train_s;
  logic                 mispred_s;

  // Fetch-side index, optionally folded with global history.
  always_comb begin
    hash_s = idx_hash(IDX_W_MAX'(f_pc[IDX_BITS+1:2]), IDX_W_MAX'(ghr_r), GSHARE != 0);
  end

  assign f_idx = hash_s[IDX_BITS-1:0];

  sat_counter_table #(
    .IDX_BITS (IDX_BITS),
    .CNT_BITS (CNT_BITS)
  ) u_pht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (f_idx),
    .rd_cnt   (rd_cnt_s),
    .wr_en    (train_s),
    .wr_idx   (e_idx),
    .wr_taken (e_actual_taken)
  );

  // Resolution of the control-flow instruction in execute; jumps never train.
  always_comb begin
    cf_s      = e_valid & (e_branch | e_jump);
    train_s   = e_valid & e_branch & ~reset;
    mispred_s = cf_s & (e_pred_taken != e_actual_taken);
    if (reset) begin
      f_pred_taken   = 1'b0;
      e_flush        = 1'b0;
      e_target_sel   = 1'b0;
      e_pred_correct = 1'b0;
    end else begin
      f_pred_taken   = rd_cnt_s[CNT_BITS-1];
      e_flush        = mispred_s;
      e_target_sel   = (~e_pred_taken & e_actual_taken) ? REDIRECT_TARGET : REDIRECT_SEQ;
      e_pred_correct = cf_s & (e_pred_taken == e_actual_taken);
    end
  end

  // Global history shifts in each trained branch outcome.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_r <= {IDX_BITS{1'b0}};
    end else if (train_s) begin
      ghr_r <= {ghr_r[IDX_BITS-2:0], e_actual_taken};
    end else begin
      ghr_r <= ghr_r;
    end
  end

  // Statistics counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches    <= {STAT_W{1'b0}};
      stat_mispredicts <= {STAT_W{1'b0}};
    end else begin
      if (cf_s && (stat_branches != {STAT_W{1'b1}})) begin
        stat_branches <= stat_branches + STAT_W'(1);
      end else begin
        stat_branches <= stat_branches;
      end
      if (mispred_s && (stat_mispredicts != {STAT_W{1'b1}})) begin
        stat_mispredicts <= stat_mispredicts + STAT_W'(1);
      end else begin
        stat_mispredicts <= stat_mispredicts;
      end
    end
  end

endmodule
